pc6001_mem_arbiter: RTL

//  Shares the single PC-6001 main-memory port between three requesters: video fetch (VDG), the HPS ROM/cart

---
 rtl/pc6001_mem_pkg.sv | 31 +++
 rtl/pc6001_mem_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pc6001_mem_pkg.sv
// Shared types for the PC-6001 main-memory arbiter.
//   owner_t    : which requester owns the current access slot
//   state_t    : arbiter state (idle / slot in progress)
//   pick_owner : fixed-priority winner selection with CPU starvation override
package pc6001_mem_pkg;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_VID,
      OWN_DL,
      OWN_CPU
   } owner_t;

   typedef enum logic {
      ST_IDLE,
      ST_ACCESS
   } state_t;

   // force_cpu only takes effect while the CPU is actually requesting.
   function automatic owner_t pick_owner(input logic vid, input logic dl,
                                         input logic cpu, input logic force_cpu);
      owner_t o;
      if (force_cpu && cpu) o = OWN_CPU;
      else if (vid)         o = OWN_VID;
      else if (dl)          o = OWN_DL;
      else if (cpu)         o = OWN_CPU;
      else                  o = OWN_NONE;
      return o;
   endfunction

endpackage

// File: rtl/pc6001_mem_arbiter.sv
// PC-6001 main-memory arbiter: shares one memory port between video fetch,
// the HPS download writer and the Z80 CPU using fixed-length access slots.
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | no slot in progress, arbitrate every cycle
// ST_ACCESS | slot in progress, cnt runs 0..ACC_CYC-1
//
// Ports:
//   clk_sys, reset_n (sync, active-low)
//   vid_req/vid_addr -> vid_ack, vid_rvalid, vid_rdata   (video reads)
//   dl_req/dl_addr/dl_wdata -> dl_ack                    (download writes)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_ack, cpu_rvalid, cpu_rdata, cpu_wait
//   mem_cs/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory
module pc6001_mem_arbiter
   import pc6001_mem_pkg::*;
#(
   parameter int AW         = 16,
   parameter int ACC_CYC    = 4,
   parameter int RD_LAT     = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   output logic          vid_rvalid,
   output logic [7:0]    vid_rdata,
   input  logic          dl_req,
   input  logic [AW-1:0] dl_addr,
   input  logic [7:0]    dl_wdata,
   output logic          dl_ack,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_wdata,
   output logic          cpu_ack,
   output logic          cpu_rvalid,
   output logic [7:0]    cpu_rdata,
   output logic          cpu_wait,
   output logic          mem_cs,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata
);

   localparam int CW = $clog2(ACC_CYC);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(ACC_CYC - 1);
   localparam logic [CW-1:0] CNT_RD     = CW'(RD_LAT);
   localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

   state_t          state_q, state_d;
   owner_t          owner_q, owner_d, win;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic            arb_pt;

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         owner_q  <= OWN_NONE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      owner_d  = owner_q;
      starve_d = starve_q;
      win      = OWN_NONE;
      arb_pt   = (state_q == ST_IDLE) || (cnt_q == CNT_LAST);
      if (arb_pt) begin
         win     = pick_owner(vid_req, dl_req, cpu_req, starve_q == STARVE_SAT);
         owner_d = win;
         cnt_d   = '0;
         state_d = (win == OWN_NONE) ? ST_IDLE : ST_ACCESS;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      // Only grants that actually pass the waiting CPU over count towards the guard.
      if (!cpu_req || win == OWN_CPU)
         starve_d = '0;
      else if (win != OWN_NONE && starve_q != STARVE_SAT)
         starve_d = starve_q + SW'(1);
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         vid_ack    <= 1'b0;
         dl_ack     <= 1'b0;
         cpu_ack    <= 1'b0;
         mem_cs     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         vid_rvalid <= 1'b0;
         cpu_rvalid <= 1'b0;
         vid_rdata  <= '0;
         cpu_rdata  <= '0;
      end else begin
         vid_ack    <= (win == OWN_VID);
         dl_ack     <= (win == OWN_DL);
         cpu_ack    <= (win == OWN_CPU);
         mem_cs     <= (win != OWN_NONE);
         vid_rvalid <= 1'b0;
         cpu_rvalid <= 1'b0;
         case (win)
            OWN_VID: begin
               mem_addr  <= vid_addr;
               mem_we    <= 1'b0;
               mem_wdata <= '0;
            end
            OWN_DL: begin
               mem_addr  <= dl_addr;
               mem_we    <= 1'b1;
               mem_wdata <= dl_wdata;
            end
            OWN_CPU: begin
               mem_addr  <= cpu_addr;
               mem_we    <= cpu_we;
               mem_wdata <= cpu_wdata;
            end
            default: ;
         endcase
         // mem_we still holds the current slot's direction at this point.
         if (state_q == ST_ACCESS && cnt_q == CNT_RD && !mem_we) begin
            if (owner_q == OWN_VID) begin
               vid_rvalid <= 1'b1;
               vid_rdata  <= mem_rdata;
            end
            if (owner_q == OWN_CPU) begin
               cpu_rvalid <= 1'b1;
               cpu_rdata  <= mem_rdata;
            end
         end
      end
   end

   assign cpu_wait = cpu_req & ~cpu_ack;

endmodule
